// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, per-scan debounce
// and a valid/ack handshake that delivers one hex code per fresh key press.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);
    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_kind_t;
    typedef struct packed {
        res_kind_t  kind;
        logic [3:0] code;
    } scan_res_t;
    typedef enum logic {ST_NONE, ST_KEY} stable_t;

    logic [3:0]        row_meta_reg, row_sync_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [1:0]        col_idx_reg;
    logic [3:0]        cap_reg [3];
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    scan_res_t         cand_reg, cand_next, scan_res;
    stable_t           state_reg, state_next;
    logic [3:0]        stable_code_reg, stable_code_next;
    logic [3:0]        key_code_reg;
    logic              key_valid_reg, overrun_reg;
    logic              tick_last, scan_done, accept, press_event;
    logic [15:0]       low_bits;
    logic [1:0]        hit_cnt;
    logic [3:0]        hit_code;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign tick_last = (tick_reg == TICK_LAST);
    assign scan_done = tick_last && (col_idx_reg == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_reg    <= '0;
            col_idx_reg <= 2'd0;
        end else if (tick_last) begin
            tick_reg    <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
        end else begin
            tick_reg <= tick_reg + 1'b1;
        end
    end

    // Columns 0..2 are latched; column 3 is read live on the scan-closing tick.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cap
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    cap_reg[gi] <= 4'hF;
                else if (tick_last && col_idx_reg == 2'(gi))
                    cap_reg[gi] <= row_sync_reg;
            end
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_n[gi] = (col_idx_reg != 2'(gi));
        end
    endgenerate

    assign low_bits = ~{row_sync_reg, cap_reg[2], cap_reg[1], cap_reg[0]};

    always_comb begin
        hit_cnt  = 2'd0;
        hit_code = 4'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (low_bits[c*4 + r]) begin
                    if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
                    hit_code = key_map(2'(r), 2'(c));
                end
            end
        end
        scan_res.kind = (hit_cnt == 2'd0) ? RES_NONE : (hit_cnt == 2'd1) ? RES_KEY : RES_MULTI;
        scan_res.code = (hit_cnt == 2'd1) ? hit_code : 4'd0;
    end

    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        cand_next    = cand_reg;
        if (scan_done) begin
            if (scan_res == cand_reg) begin
                if (deb_cnt_reg != DEB_MAX) deb_cnt_next = deb_cnt_reg + 1'b1;
            end else begin
                deb_cnt_next = DEB_W'(1);
                cand_next    = scan_res;
            end
        end
    end

    // A multi-key candidate never reaches the stable state, so ghosted chords are ignored.
    assign accept = scan_done && (deb_cnt_next == DEB_MAX) && (cand_next.kind != RES_MULTI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_reg     <= '0;
            cand_reg        <= '{kind: RES_NONE, code: 4'd0};
            state_reg       <= ST_NONE;
            stable_code_reg <= 4'd0;
        end else begin
            deb_cnt_reg     <= deb_cnt_next;
            cand_reg        <= cand_next;
            state_reg       <= state_next;
            stable_code_reg <= stable_code_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        stable_code_next = stable_code_reg;
        if (accept) begin
            if (cand_next.kind == RES_KEY) begin
                state_next       = ST_KEY;
                stable_code_next = cand_next.code;
            end else begin
                state_next = ST_NONE;
            end
        end
    end

    always_comb begin
        key_down    = (state_reg == ST_KEY);
        press_event = (state_reg == ST_NONE) && (state_next == ST_KEY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (press_event) begin
            if (!key_valid_reg || key_ack) begin
                key_code_reg  <= stable_code_next;
                key_valid_reg <= 1'b1;
                overrun_reg   <= 1'b0;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (key_ack && key_valid_reg) begin
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end
    end

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes row/column contacts, and
// expected key codes are queued when presses are made and popped on delivery.
module tb_keypad_scanner;
    localparam int ST   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * ST;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    logic [3:0] held [4];
    logic [3:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .reset_n(reset_n), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
        .key_down(key_down), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Row r is pulled low when its contact in the currently driven column is closed.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) row_n[r] = ~|(held[r] & ~col_n);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) held[r] = 4'h0;
    endtask

    task automatic press(input int r, input int c);
        held[r][c] = 1'b1;
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = key_valid;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = key_valid;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset_n = 1'b0; key_ack = 1'b0; release_all();
        step(3);
        n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", col_n); end
        n_vec++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h want 0", key_code); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL reset_down: got %b want 0", key_down); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            exp_col = ~(4'b0001 << ((j / 4) % 4));
            n_vec++;
            if (col_n !== exp_col) begin n_err++; $display("FAIL scan_col[%0d]: got %b want %b", j, col_n, exp_col); end
        end
    endtask

    task automatic test_single_press();
        bit seen;
        logic [3:0] exp;
        press(1, 1);
        exp_q.push_back(4'h5);
        wait_valid(60, seen);
        exp = exp_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL press5_valid: got timeout want key_valid=1"); end
        n_vec++; if (key_code !== exp) begin n_err++; $display("FAIL press5_code: got %h want %h", key_code, exp); end
        n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL press5_down: got %b want 1", key_down); end
        step(10 * SCAN);
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL hold5_valid: got %b want 1", key_valid); end
        n_vec++; if (key_code !== 4'h5) begin n_err++; $display("FAIL hold5_code: got %h want 5", key_code); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL hold5_no_event: overrun got %b want 0", overrun); end
    endtask

    task automatic test_ack_release();
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ack_valid: got %b want 0", key_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ack_overrun: got %b want 0", overrun); end
        release_all();
        step(1);
        n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL release_early_down: got %b want 1", key_down); end
        step(4 * SCAN);
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL release_down: got %b want 0", key_down); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b want 0", key_valid); end
        key_ack = 1'b1; step(1); key_ack = 1'b0; step(1);
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL idle_ack_valid: got %b want 0", key_valid); end
    endtask

    task automatic test_bounce();
        press(3, 2);
        step(SCAN);
        release_all();
        step(4 * SCAN);
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL bounce_down: got %b want 0", key_down); end
        press(0, 0); press(0, 1);
        step(5 * SCAN);
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL multi_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL multi_down: got %b want 0", key_down); end
        release_all();
        step(4 * SCAN);
    endtask

    task automatic test_overrun();
        bit seen;
        bit found;
        logic [3:0] exp;
        logic [3:0] prev_col;
        press(0, 2);
        exp_q.push_back(4'h3);
        wait_valid(60, seen);
        exp = exp_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL press3_valid: got timeout want key_valid=1"); end
        n_vec++; if (key_code !== exp) begin n_err++; $display("FAIL press3_code: got %h want %h", key_code, exp); end
        release_all(); step(4 * SCAN);
        press(2, 2);
        seen = overrun;
        for (int i = 0; i < 60 && !seen; i++) begin step(1); seen = overrun; end
        n_vec++; if (!seen) begin n_err++; $display("FAIL press9_overrun: got timeout want overrun=1"); end
        n_vec++; if (key_code !== 4'h3) begin n_err++; $display("FAIL press9_code_kept: got %h want 3", key_code); end
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL press9_valid: got %b want 1", key_valid); end
        release_all(); step(4 * SCAN);
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack_valid: got %b want 0", key_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_ack_overrun: got %b want 0", overrun); end
        press(0, 0);
        exp_q.push_back(4'h1);
        wait_valid(60, seen);
        exp = exp_q.pop_front();
        n_vec++; if (!seen || key_code !== exp) begin n_err++; $display("FAIL press1_code: got %h (valid %b) want %h", key_code, key_valid, exp); end
        release_all(); step(4 * SCAN);
        // Align to a scan boundary so the press event cycle is known in advance.
        found = 1'b0;
        prev_col = col_n;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (col_n == 4'b1110 && prev_col != 4'b1110) found = 1'b1;
            prev_col = col_n;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL scan_align: got timeout want col_n wrap to 1110"); end
        press(1, 2);
        exp_q.push_back(4'h6);
        step(2 * SCAN - 1);
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        exp = exp_q.pop_front();
        n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL ack_event_valid: got %b want 1", key_valid); end
        n_vec++; if (key_code !== exp) begin n_err++; $display("FAIL ack_event_code: got %h want %h", key_code, exp); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ack_event_overrun: got %b want 0", overrun); end
        key_ack = 1'b1; step(1); key_ack = 1'b0;
        release_all(); step(4 * SCAN);
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [3:0] exp;
        press(0, 3);
        exp_q.push_back(4'hA);
        wait_valid(60, seen);
        exp = exp_q.pop_front();
        n_vec++; if (!seen || key_code !== exp) begin n_err++; $display("FAIL pressA_code: got %h (valid %b) want %h", key_code, key_valid, exp); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", key_valid); end
        n_vec++; if (key_down !== 1'b0) begin n_err++; $display("FAIL midrst_down: got %b want 0", key_down); end
        n_vec++; if (col_n !== 4'b1110) begin n_err++; $display("FAIL midrst_col: got %b want 1110", col_n); end
        n_vec++; if (key_code !== 4'h0) begin n_err++; $display("FAIL midrst_code: got %h want 0", key_code); end
        step(2);
        reset_n = 1'b1;
        exp_q.push_back(4'hA);
        wait_valid(60, seen);
        exp = exp_q.pop_front();
        n_vec++; if (!seen) begin n_err++; $display("FAIL postrst_valid: got timeout want key_valid=1"); end
        n_vec++; if (key_code !== exp) begin n_err++; $display("FAIL postrst_code: got %h want %h", key_code, exp); end
        n_vec++; if (key_down !== 1'b1) begin n_err++; $display("FAIL postrst_down: got %b want 1", key_down); end
        release_all();
        step(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        release_all();
        key_ack = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_single_press();
        test_ack_release();
        test_bounce();
        test_overrun();
        test_reset_mid();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
